// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration-time helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  // Number of digit slices needed to cover the operand width.
  function automatic int unsigned calc_ndig(input int unsigned width,
                                            input int unsigned digit);
    return (digit == 0) ? 1 : width / digit;
  endfunction

  // Digit counter width: max(1, clog2(ndig)).
  function automatic int unsigned calc_cnt_w(input int unsigned ndig);
    return (ndig <= 2) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit adder slice; also exposes the carry into its top bit.
module digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] full;

  always_comb begin
    full  = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    s     = full[DIGIT-1:0];
    cout  = full[DIGIT];
    // Carry into the top bit recovered from its sum bit: s = a ^ b ^ c.
    c_msb = full[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit a + b + ci computed DIGIT bits per clock,
// with valid/ready handshakes on the operand and result sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGIT  = 4,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int unsigned CW   = calc_cnt_w(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_adder: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
  end

  sa_state_t        state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] s;
  logic             c;
  logic             c_msb;
  logic             load;
  logic [WIDTH-1:0] sum_next;

  digit_adder #(.DIGIT(DIGIT)) u_slice (
    .a     (a_sh[DIGIT-1:0]),
    .b     (b_sh[DIGIT-1:0]),
    .cin   (carry),
    .s     (s),
    .cout  (c),
    .c_msb (c_msb)
  );

  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    load     = in_valid && in_ready;
    // New digit enters at the top; the cast drops the digit shifted out below.
    sum_next = WIDTH'({s, sum} >> DIGIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (load) begin
      a_sh      <= a;
      b_sh      <= b;
      carry     <= ci;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b1;
      state     <= BUSY;
    end else begin
      case (state)
        IDLE: ;
        BUSY: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          carry <= c;
          sum   <= sum_next;
          if (cnt == LAST) begin
            cnt       <= '0;
            co        <= c;
            ovf       <= SIGNED ? (c ^ c_msb) : c;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          cnt       <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: five adder configurations driven by directed and random
// operations, compared against plain arithmetic a + b + ci.
module tb_serial_adder;

  localparam int NDUT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a   = '0;
  logic [15:0] b   = '0;
  logic        ci  = 1'b0;

  logic        in_valid_v [NDUT];
  logic        out_ready_v[NDUT];
  logic        in_ready_v [NDUT];
  logic        out_valid_v[NDUT];
  logic [15:0] sum_v      [NDUT];
  logic        co_v       [NDUT];
  logic        ovf_v      [NDUT];
  logic        busy_v     [NDUT];
  logic [7:0]  sum8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Configurations: 0=16/4 unsigned, 1=16/4 signed, 2=16/1, 3=16/16, 4=8/2.
  serial_adder #(.WIDTH(16), .DIGIT(4), .SIGNED(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .sum(sum_v[0]), .co(co_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0]));
  serial_adder #(.WIDTH(16), .DIGIT(4), .SIGNED(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .sum(sum_v[1]), .co(co_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1]));
  serial_adder #(.WIDTH(16), .DIGIT(1), .SIGNED(1'b0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .sum(sum_v[2]), .co(co_v[2]), .ovf(ovf_v[2]), .busy(busy_v[2]));
  serial_adder #(.WIDTH(16), .DIGIT(16), .SIGNED(1'b0)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]),
    .sum(sum_v[3]), .co(co_v[3]), .ovf(ovf_v[3]), .busy(busy_v[3]));
  serial_adder #(.WIDTH(8), .DIGIT(2), .SIGNED(1'b0)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[4]), .in_ready(in_ready_v[4]),
    .a(a[7:0]), .b(b[7:0]), .ci(ci), .out_valid(out_valid_v[4]), .out_ready(out_ready_v[4]),
    .sum(sum8), .co(co_v[4]), .ovf(ovf_v[4]), .busy(busy_v[4]));

  always_comb sum_v[4] = {8'h00, sum8};

  function automatic int width_of(input int i);
    return (i == 4) ? 8 : 16;
  endfunction

  function automatic int ndig_of(input int i);
    case (i)
      2:       return 16;
      3:       return 1;
      4:       return 4;
      default: return 4;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition, overflow from operand/result signs.
  task automatic model(input int i, input logic [15:0] av, input logic [15:0] bv,
                       input logic civ, output logic [15:0] es, output logic eco,
                       output logic eovf);
    int unsigned w, mask, am, bm, tot, sa, sb, ss;
    w    = width_of(i);
    mask = (32'd1 << w) - 1;
    am   = av & mask;
    bm   = bv & mask;
    tot  = am + bm + civ;
    es   = 16'(tot & mask);
    eco  = tot[w];
    sa   = (am >> (w - 1)) & 1;
    sb   = (bm >> (w - 1)) & 1;
    ss   = (tot >> (w - 1)) & 1;
    eovf = (i == 1) ? ((sa == sb) && (ss != sa)) : eco;
  endtask

  // Present one operation, check latency/busy, then drain with optional throttling.
  task automatic run_op(input int i, input logic [15:0] av, input logic [15:0] bv,
                        input logic civ, input bit throttle);
    logic [15:0] es;
    logic        eco, eovf, acc;
    int          n, busy_cnt, guard;
    model(i, av, bv, civ, es, eco, eovf);
    guard = 0;
    while (in_ready_v[i] !== 1'b1 && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    check("in_ready_before_op", in_ready_v[i], 1'b1);
    a = av; b = bv; ci = civ; in_valid_v[i] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[i] = 1'b0;
    busy_cnt = (busy_v[i] === 1'b1) ? 1 : 0;
    n = 0;
    while (out_valid_v[i] !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
      if (out_valid_v[i] !== 1'b1 && busy_v[i] === 1'b1) busy_cnt++;
    end
    check("latency", n, ndig_of(i));
    check("busy_cycles", busy_cnt, ndig_of(i));
    check("busy_low_in_done", busy_v[i], 1'b0);
    check("sum", sum_v[i], es);
    check("co", co_v[i], eco);
    check("ovf", ovf_v[i], eovf);
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 200) begin
      out_ready_v[i] = throttle ? ($urandom_range(0, 2) == 0) : 1'b1;
      #1;
      check("in_ready_follows_out_ready", in_ready_v[i], out_ready_v[i]);
      check("sum_stable", sum_v[i], es);
      acc = out_ready_v[i];
      @(posedge clk); #1; guard++;
    end
    check("drain_in_bound", acc, 1'b1);
    out_ready_v[i] = 1'b0;
    check("out_valid_after_consume", out_valid_v[i], 1'b0);
    check("sum_held_after_consume", sum_v[i], es);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] es, hold_sum;
    logic        eco, eovf, hold_co, hold_ovf;
    int          n;
    for (int i = 0; i < NDUT; i++) begin
      in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b0;
    end

    // Reset state, with in_valid asserted during reset being ignored.
    #2;
    for (int i = 0; i < NDUT; i++) in_valid_v[i] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check("rst_out_valid", out_valid_v[i], 1'b0);
      check("rst_sum", sum_v[i], 16'h0000);
      check("rst_busy", busy_v[i], 1'b0);
      check("rst_in_ready", in_ready_v[i], 1'b1);
      check("rst_co_ovf", {co_v[i], ovf_v[i]}, 2'b00);
      in_valid_v[i] = 1'b0;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < NDUT; i++) check("idle_after_rst", busy_v[i], 1'b0);

    // Directed arithmetic cases.
    run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
    check("t1_sum", sum_v[0], 16'h5555);
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check("t2_co_ovf", {co_v[0], ovf_v[0], sum_v[0]}, {2'b11, 16'h0000});
    run_op(0, 16'h00FF, 16'h0F01, 1'b1, 1'b0);
    check("t2_ripple", {co_v[0], sum_v[0]}, {1'b0, 16'h1001});
    run_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    check("t3_signed_ovf", {co_v[1], ovf_v[1], sum_v[1]}, {2'b01, 16'h8000});
    run_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check("t3_signed_noovf", {co_v[1], ovf_v[1], sum_v[1]}, {2'b10, 16'h0000});
    run_op(3, 16'h0000, 16'h0000, 1'b1, 1'b0);
    check("t6_digit16", sum_v[3], 16'h0001);

    // Backpressure in DONE, then back-to-back acceptance.
    a = 16'h0A0B; b = 16'h0102; ci = 1'b1; in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    n = 0;
    while (out_valid_v[0] !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    check("bp_latency", n, 4);
    hold_sum = sum_v[0]; hold_co = co_v[0]; hold_ovf = ovf_v[0];
    check("bp_sum", hold_sum, 16'h0B0E);
    for (int k = 0; k < 10; k++) begin
      a = 16'($urandom); b = 16'($urandom); in_valid_v[0] = k[0];
      #1;
      check("bp_in_ready", in_ready_v[0], 1'b0);
      @(posedge clk); #1;
      check("bp_hold", {out_valid_v[0], co_v[0], ovf_v[0], sum_v[0]},
            {1'b1, hold_co, hold_ovf, hold_sum});
    end
    a = 16'h8001; b = 16'h8001; ci = 1'b0; in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0; out_ready_v[0] = 1'b0;
    check("b2b_out_valid_low", out_valid_v[0], 1'b0);
    check("b2b_busy", busy_v[0], 1'b1);
    n = 0;
    while (out_valid_v[0] !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    check("b2b_latency", n, 4);
    check("b2b_result", {co_v[0], ovf_v[0], sum_v[0]}, {2'b11, 16'h0002});
    out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[0] = 1'b0;

    // Reset mid-operation.
    a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1; in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid_v[0], 1'b0);
    check("midrst_sum", sum_v[0], 16'h0000);
    check("midrst_busy", busy_v[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 16'h0001, 16'h0002, 1'b0, 1'b0);
    check("after_abort", {co_v[0], sum_v[0]}, {1'b0, 16'h0003});

    // Random sweep over all configurations with output throttling.
    for (int i = 0; i < NDUT; i++) begin
      for (int k = 0; k < 200; k++) begin
        run_op(i, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
      end
    end
    model(4, 16'h00FF, 16'h0001, 1'b0, es, eco, eovf);
    run_op(4, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    check("w8_wrap", {co_v[4], sum_v[4]}, {eco, es});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
